// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, single-entry output
// register toward decode, redirect handling with a flush state, and a terminal HLT.
module fetch_unit #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [15:0]       imem_addr,
  input  logic              imem_rdy,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              stall,
  input  logic              redirect,
  input  logic [15:0]       redirect_pc,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [15:0]       pc_plus2,
  output logic              halted
);

  typedef enum logic [1:0] {
    FETCH,
    VALID,
    FLUSH,
    HALT
  } state_t;

  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t              state, state_nxt;
  logic                armed;
  logic [15:0]         pc, pc_nxt;
  logic [15:0]         flush_addr, flush_addr_nxt;
  logic [DATA_W-1:0]   instr_nxt;
  logic [15:0]         pc_plus2_nxt;

  function automatic logic [15:0] align_pc(input logic [15:0] a);
    return a & 16'hFFFE;
  endfunction

  // Everything is cleared by reset, including the instruction and pc_plus2
  // registers, so decode never sees stale values after a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      armed      <= 1'b0;
      pc         <= 16'h0000;
      flush_addr <= 16'h0000;
      instr      <= '0;
      pc_plus2   <= 16'h0000;
    end else begin
      state      <= state_nxt;
      armed      <= 1'b1;
      pc         <= pc_nxt;
      flush_addr <= flush_addr_nxt;
      instr      <= instr_nxt;
      pc_plus2   <= pc_plus2_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    flush_addr_nxt = flush_addr;
    instr_nxt      = instr;
    pc_plus2_nxt   = pc_plus2;
    imem_req       = 1'b0;
    imem_addr      = pc;
    instr_valid    = 1'b0;
    halted         = 1'b0;

    case (state)
      FETCH: begin
        // armed holds the first request back until the first edge after reset
        imem_req = armed;
        if (redirect) begin
          pc_nxt = align_pc(redirect_pc);
          if (armed && !imem_rdy) begin
            flush_addr_nxt = pc;
            state_nxt      = FLUSH;
          end else begin
            state_nxt = FETCH;
          end
        end else if (armed && imem_rdy) begin
          instr_nxt    = imem_data;
          pc_plus2_nxt = pc + 16'd2;
          pc_nxt       = pc + 16'd2;
          state_nxt    = VALID;
        end
      end

      VALID: begin
        instr_valid = 1'b1;
        if (redirect) begin
          pc_nxt    = align_pc(redirect_pc);
          state_nxt = FETCH;
        end else if (!stall) begin
          state_nxt = (instr[DATA_W-1 -: 4] == OP_HLT) ? HALT : FETCH;
        end
      end

      FLUSH: begin
        // keep the abandoned request alive with its original address; drop its data
        imem_req  = 1'b1;
        imem_addr = flush_addr;
        if (redirect) begin
          pc_nxt = align_pc(redirect_pc);
        end
        if (imem_rdy) begin
          state_nxt = FETCH;
        end
      end

      HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-programmable memory model answers
// requests, while monitors compare accepted addresses and consumed instructions.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] pc_plus2;
  logic        halted;

  fetch_unit #(.DATA_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdy    (imem_rdy),
    .imem_data   (imem_data),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc_plus2    (pc_plus2),
    .halted      (halted)
  );

  typedef struct {
    logic [15:0] i;
    logic [15:0] p;
  } exp_t;

  exp_t        iq[$];
  logic [15:0] aq[$];
  logic [15:0] mem [logic [15:0]];
  int          lat;
  int          cnt;
  int          errors;
  int          checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'h0000;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: condition not reached within cycle budget", nm);
  endtask

  // memory model: answers after lat cycles of asserted request
  initial begin
    imem_rdy  = 1'b0;
    imem_data = 16'h0000;
    cnt       = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        imem_rdy = 1'b0;
        cnt      = 0;
      end else begin
        #1;
        imem_rdy = 1'b0;
        if (rst_n && imem_req) begin
          cnt++;
          if (cnt >= lat) begin
            imem_rdy  = 1'b1;
            imem_data = rd(imem_addr);
            cnt       = 0;
          end
        end
      end
    end
  end

  // monitor: pops expectations whenever a request is accepted or an instruction consumed
  initial begin
    exp_t        e;
    logic [15:0] a;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (imem_req && imem_rdy) begin
          if (aq.size() == 0) begin
            chk("unexpected_req_addr", imem_addr, 16'hDEAD);
          end else begin
            a = aq.pop_front();
            chk("req_addr", imem_addr, a);
          end
        end
        if (instr_valid && !stall && !redirect) begin
          if (iq.size() == 0) begin
            chk("unexpected_instr", instr, 16'hDEAD);
          end else begin
            e = iq.pop_front();
            chk("instr", instr, e.i);
            chk("pc_plus2", pc_plus2, e.p);
          end
        end
      end
    end
  end

  task automatic push_i(input logic [15:0] i, input logic [15:0] p);
    exp_t e;
    e.i = i;
    e.p = p;
    iq.push_back(e);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    #1;
    chk("rst_imem_req", 16'(imem_req), 16'h0000);
    chk("rst_instr_valid", 16'(instr_valid), 16'h0000);
    chk("rst_halted", 16'(halted), 16'h0000);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_pc_plus2", pc_plus2, 16'h0000);
    chk("rst_imem_addr", imem_addr, 16'h0000);
    repeat (2) @(negedge clk);
    chk("rst_hold_imem_req", 16'(imem_req), 16'h0000);
    rst_n = 1'b1;
    #1;
    chk("post_rst_no_req_before_edge", 16'(imem_req), 16'h0000);
    @(posedge clk);
    #1;
    chk("first_req", 16'(imem_req), 16'h0001);
    chk("first_req_addr", imem_addr, 16'h0000);
  endtask

  task automatic wait_req(input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (imem_req) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now(nm);
  endtask

  task automatic finish_halt(input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (halted) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now(nm);
    repeat (3) begin
      @(negedge clk);
      chk("halt_halted", 16'(halted), 16'h0001);
      chk("halt_no_req", 16'(imem_req), 16'h0000);
      chk("halt_no_valid", 16'(instr_valid), 16'h0000);
    end
    chk("instr_q_drained", 16'(iq.size()), 16'h0000);
    chk("addr_q_drained", 16'(aq.size()), 16'h0000);
    iq.delete();
    aq.delete();
    mem.delete();
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    lat         = 1;
    rst_n       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    #3;

    // straight-line fetch ending on HLT; HALT ignores redirect and stall
    mem[16'h0000] = 16'h1234;
    mem[16'h0002] = 16'hF000;
    lat = 1;
    aq.push_back(16'h0000);
    aq.push_back(16'h0002);
    push_i(16'h1234, 16'h0002);
    push_i(16'hF000, 16'h0004);
    do_reset();
    finish_halt("t1_halt");
    @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = 16'h0020;
    stall       = 1'b1;
    repeat (2) @(negedge clk);
    chk("halt_ignores_redirect", 16'(halted), 16'h0001);
    chk("halt_ignores_redirect_req", 16'(imem_req), 16'h0000);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    stall    = 1'b0;

    // stalled instruction is held for four cycles with no new request
    mem[16'h0000] = 16'h1234;
    mem[16'h0002] = 16'hF000;
    lat = 1;
    aq.push_back(16'h0000);
    aq.push_back(16'h0002);
    push_i(16'h1234, 16'h0002);
    push_i(16'hF000, 16'h0004);
    do_reset();
    stall = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (instr_valid) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) fail_now("t2_valid");
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk("stall_valid", 16'(instr_valid), 16'h0001);
      chk("stall_instr", instr, 16'h1234);
      chk("stall_pc_plus2", pc_plus2, 16'h0002);
      chk("stall_no_req", 16'(imem_req), 16'h0000);
      if (k == 2) begin
        @(posedge clk);
        #1;
        stall = 1'b0;
      end
    end
    finish_halt("t2_halt");

    // redirect after one cycle of a slow request: flush old address, refetch at 0x0040
    mem[16'h0000] = 16'h1234;
    mem[16'h0040] = 16'h2222;
    mem[16'h0042] = 16'hF000;
    lat = 3;
    aq.push_back(16'h0000);
    aq.push_back(16'h0040);
    aq.push_back(16'h0042);
    push_i(16'h2222, 16'h0042);
    push_i(16'hF000, 16'h0044);
    do_reset();
    wait_req("t3_req");
    redirect    = 1'b1;
    redirect_pc = 16'h0041;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("flush_req_held", 16'(imem_req), 16'h0001);
    chk("flush_old_addr", imem_addr, 16'h0000);
    chk("flush_no_valid", 16'(instr_valid), 16'h0000);
    finish_halt("t3_halt");

    // redirect coincident with a returning HLT word: the word must not halt
    mem[16'h0000] = 16'hF000;
    mem[16'h0080] = 16'h3333;
    mem[16'h0082] = 16'hF000;
    lat = 1;
    aq.push_back(16'h0000);
    aq.push_back(16'h0080);
    aq.push_back(16'h0082);
    push_i(16'h3333, 16'h0082);
    push_i(16'hF000, 16'h0084);
    do_reset();
    wait_req("t4_req");
    chk("t4_rdy_coincident", 16'(imem_rdy), 16'h0001);
    redirect    = 1'b1;
    redirect_pc = 16'h0080;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("discarded_hlt_not_halted", 16'(halted), 16'h0000);
    chk("discarded_hlt_no_valid", 16'(instr_valid), 16'h0000);
    chk("redirect_next_addr", imem_addr, 16'h0080);
    finish_halt("t4_halt");

    // redirect in VALID to 0xFFFF (bit 0 dropped) and wrap to 0x0000
    mem[16'h0000] = 16'h1234;
    mem[16'h0002] = 16'hF000;
    mem[16'hFFFE] = 16'h5555;
    lat = 1;
    aq.push_back(16'h0000);
    aq.push_back(16'hFFFE);
    aq.push_back(16'h0000);
    aq.push_back(16'h0002);
    push_i(16'h5555, 16'h0000);
    push_i(16'h1234, 16'h0002);
    push_i(16'hF000, 16'h0004);
    do_reset();
    wait_req("t5_req");
    @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("wrap_fetch_addr", imem_addr, 16'hFFFE);
    finish_halt("t5_halt");

    // reset mid-request at pc=0x0010 abandons it; refetch from 0x0000
    mem[16'h0000] = 16'h1234;
    mem[16'h0002] = 16'hF000;
    lat = 3;
    aq.push_back(16'h0000);
    aq.push_back(16'h0000);
    aq.push_back(16'h0002);
    push_i(16'h1234, 16'h0002);
    push_i(16'hF000, 16'h0004);
    do_reset();
    wait_req("t6_req");
    redirect    = 1'b1;
    redirect_pc = 16'h0010;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (imem_req && imem_addr == 16'h0010) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) fail_now("t6_req_0010");
    end
    do_reset();
    finish_halt("t6_halt");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
